req_tag_alloc: RTL and testbench

Tag allocator for the request/completion path. It accepts new requests through a valid/ready handshake and assigns each one the lowest-numbered free tag. It drives the init interface of the downstream per-tag history store (`init_vld`/`init_tag`/`init_his`). It returns tags to the pool when the final completion for that tag arrives, and it supports a flush/drain sequence.

---
 rtl/req_tag_alloc.sv | 100 ++++++++++
 tb/tb_req_tag_alloc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_tag_alloc.sv
// Request tag allocator: hands out the lowest free tag per accepted request,
// reclaims tags on their final completion, and sequences a flush/drain.
module req_tag_alloc #(
  parameter int TAG_COUNT = 8,
  parameter int HIS_WIDTH = 4,
  parameter int TAG_WIDTH = $clog2(TAG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [HIS_WIDTH-1:0] req_his,
  output logic                 init_vld,
  output logic [TAG_WIDTH-1:0] init_tag,
  output logic [HIS_WIDTH-1:0] init_his,
  input  logic                 cpl_vld,
  input  logic [TAG_WIDTH-1:0] cpl_tag,
  input  logic                 cpl_last,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [TAG_WIDTH:0]   free_cnt,
  output logic                 err_free
);

  // state | meaning
  // RUN   | normal operation, requests accepted while tags are free
  // DRAIN | no new requests, waiting for every tag to be freed
  // DONE  | one-cycle flush_done pulse, then back to RUN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [TAG_WIDTH:0] CNT_FULL = (TAG_WIDTH + 1)'(TAG_COUNT);

  state_t                 state, state_nxt;
  logic [TAG_COUNT-1:0]   busy, busy_nxt;
  logic [TAG_WIDTH:0]     cnt_nxt;
  logic [TAG_WIDTH-1:0]   alloc_tag;
  logic                   accept;
  logic                   cpl_final;
  logic                   free_ok;
  logic                   free_bad;

  assign req_rdy    = rst_n && (state == ST_RUN) && (free_cnt != '0);
  assign accept     = req_vld && req_rdy;
  assign cpl_final  = cpl_vld && cpl_last;
  assign free_ok    = cpl_final && busy[cpl_tag];
  assign free_bad   = cpl_final && !busy[cpl_tag];
  assign flush_done = (state == ST_DONE);

  // Scan from the top so the last hit written is the lowest free index.
  always_comb begin
    alloc_tag = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_tag = TAG_WIDTH'(i);
    end
  end

  always_comb begin
    busy_nxt = busy;
    if (accept)  busy_nxt[alloc_tag] = 1'b1;
    if (free_ok) busy_nxt[cpl_tag]   = 1'b0;
    cnt_nxt = free_cnt + {{TAG_WIDTH{1'b0}}, free_ok} - {{TAG_WIDTH{1'b0}}, accept};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (free_cnt == CNT_FULL) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      busy     <= '0;
      free_cnt <= CNT_FULL;
      init_vld <= 1'b0;
      init_tag <= '0;
      init_his <= '0;
      err_free <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= busy_nxt;
      free_cnt <= cnt_nxt;
      init_vld <= accept;
      err_free <= free_bad;
      if (accept) begin
        init_tag <= alloc_tag;
        init_his <= req_his;
      end
    end
  end

endmodule

// File: tb/tb_req_tag_alloc.sv
// Directed bench for req_tag_alloc: allocation order, reuse, simultaneous
// alloc/free, bad free, flush sequencing and reset mid-drain.
module tb_req_tag_alloc;

  logic       clk;
  logic       rst_n;
  logic       req_vld;
  logic       req_rdy;
  logic [3:0] req_his;
  logic       init_vld;
  logic [2:0] init_tag;
  logic [3:0] init_his;
  logic       cpl_vld;
  logic [2:0] cpl_tag;
  logic       cpl_last;
  logic       flush_req;
  logic       flush_done;
  logic [3:0] free_cnt;
  logic       err_free;

  int errors = 0;
  int checks = 0;

  req_tag_alloc #(.TAG_COUNT(8), .HIS_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_his    (req_his),
    .init_vld   (init_vld),
    .init_tag   (init_tag),
    .init_his   (init_his),
    .cpl_vld    (cpl_vld),
    .cpl_tag    (cpl_tag),
    .cpl_last   (cpl_last),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .free_cnt   (free_cnt),
    .err_free   (err_free)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs are observed 1 time unit after the edge, inputs set there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (req_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy_low: got %0d expected 0", req_rdy); end
    checks++; if (free_cnt !== 4'd8) begin errors++; $display("FAIL reset_free_cnt: got %0d expected 8", free_cnt); end
    checks++; if (init_vld !== 1'b0 || init_tag !== 3'd0 || init_his !== 4'd0) begin errors++; $display("FAIL reset_init: got vld=%0d tag=%0d his=%0d expected 0/0/0", init_vld, init_tag, init_his); end
    checks++; if (flush_done !== 1'b0 || err_free !== 1'b0) begin errors++; $display("FAIL reset_pulses: got flush_done=%0d err_free=%0d expected 0/0", flush_done, err_free); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy_release: got %0d expected 1", req_rdy); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 10; c++) begin
      req_vld = 1'b1;
      req_his = 4'(c);
      tick();
      if (c < 8) begin
        checks++; if (init_vld !== 1'b1 || init_tag !== 3'(c) || init_his !== 4'(c)) begin errors++; $display("FAIL fill_%0d: got vld=%0d tag=%0d his=%0d expected 1/%0d/%0d", c, init_vld, init_tag, init_his, c, c); end
      end else begin
        checks++; if (init_vld !== 1'b0 || init_tag !== 3'd7 || init_his !== 4'd7) begin errors++; $display("FAIL fill_hold_%0d: got vld=%0d tag=%0d his=%0d expected 0/7/7", c, init_vld, init_tag, init_his); end
      end
      if (c == 7) begin
        checks++; if (req_rdy !== 1'b0 || free_cnt !== 4'd0) begin errors++; $display("FAIL fill_full: got rdy=%0d free_cnt=%0d expected 0/0", req_rdy, free_cnt); end
      end
    end
    req_vld = 1'b0;
  endtask

  task automatic test_ooo_free();
    cpl_vld = 1'b1; cpl_last = 1'b1; cpl_tag = 3'd5;
    tick();
    checks++; if (free_cnt !== 4'd1 || req_rdy !== 1'b1) begin errors++; $display("FAIL ooo_free5: got free_cnt=%0d rdy=%0d expected 1/1", free_cnt, req_rdy); end
    cpl_tag = 3'd2;
    tick();
    checks++; if (free_cnt !== 4'd2) begin errors++; $display("FAIL ooo_free2: got free_cnt=%0d expected 2", free_cnt); end
    cpl_last = 1'b0; cpl_tag = 3'd3;
    tick();
    checks++; if (free_cnt !== 4'd2 || err_free !== 1'b0) begin errors++; $display("FAIL ooo_nonlast: got free_cnt=%0d err=%0d expected 2/0", free_cnt, err_free); end
    cpl_vld = 1'b0;
    req_vld = 1'b1; req_his = 4'hA;
    tick();
    checks++; if (init_vld !== 1'b1 || init_tag !== 3'd2 || init_his !== 4'hA) begin errors++; $display("FAIL ooo_reuse_a: got vld=%0d tag=%0d his=%0d expected 1/2/10", init_vld, init_tag, init_his); end
    req_his = 4'hB;
    tick();
    checks++; if (init_tag !== 3'd5 || init_his !== 4'hB || free_cnt !== 4'd0) begin errors++; $display("FAIL ooo_reuse_b: got tag=%0d his=%0d free_cnt=%0d expected 5/11/0", init_tag, init_his, free_cnt); end
    req_vld = 1'b0;
  endtask

  task automatic test_simul();
    cpl_vld = 1'b1; cpl_last = 1'b1; cpl_tag = 3'd7;
    tick();
    checks++; if (free_cnt !== 4'd1) begin errors++; $display("FAIL simul_prep: got free_cnt=%0d expected 1", free_cnt); end
    cpl_tag = 3'd0;
    req_vld = 1'b1; req_his = 4'h3;
    tick();
    checks++; if (init_vld !== 1'b1 || init_tag !== 3'd7 || free_cnt !== 4'd1) begin errors++; $display("FAIL simul_edge: got vld=%0d tag=%0d free_cnt=%0d expected 1/7/1", init_vld, init_tag, free_cnt); end
    cpl_vld = 1'b0;
    req_his = 4'h4;
    tick();
    checks++; if (init_tag !== 3'd0 || init_his !== 4'h4 || free_cnt !== 4'd0) begin errors++; $display("FAIL simul_next: got tag=%0d his=%0d free_cnt=%0d expected 0/4/0", init_tag, init_his, free_cnt); end
    req_vld = 1'b0;
  endtask

  task automatic test_bad_free();
    cpl_vld = 1'b1; cpl_last = 1'b1; cpl_tag = 3'd4;
    tick();
    checks++; if (free_cnt !== 4'd1 || err_free !== 1'b0) begin errors++; $display("FAIL bad_prep: got free_cnt=%0d err=%0d expected 1/0", free_cnt, err_free); end
    tick();
    checks++; if (err_free !== 1'b1 || free_cnt !== 4'd1) begin errors++; $display("FAIL bad_pulse: got err=%0d free_cnt=%0d expected 1/1", err_free, free_cnt); end
    cpl_vld = 1'b0;
    tick();
    checks++; if (err_free !== 1'b0 || free_cnt !== 4'd1) begin errors++; $display("FAIL bad_after: got err=%0d free_cnt=%0d expected 0/1", err_free, free_cnt); end
    req_vld = 1'b1; req_his = 4'h6;
    tick();
    checks++; if (init_tag !== 3'd4 || free_cnt !== 4'd0) begin errors++; $display("FAIL bad_busy_kept: got tag=%0d free_cnt=%0d expected 4/0", init_tag, free_cnt); end
    req_vld = 1'b0;
  endtask

  task automatic test_flush_idle();
    do_reset();
    flush_req = 1'b1;
    tick();
    checks++; if (flush_done !== 1'b0 || req_rdy !== 1'b0) begin errors++; $display("FAIL idle_drain: got done=%0d rdy=%0d expected 0/0", flush_done, req_rdy); end
    flush_req = 1'b0;
    tick();
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL idle_done: got %0d expected 1", flush_done); end
    tick();
    checks++; if (flush_done !== 1'b0 || req_rdy !== 1'b1) begin errors++; $display("FAIL idle_back: got done=%0d rdy=%0d expected 0/1", flush_done, req_rdy); end
  endtask

  task automatic test_flush();
    do_reset();
    req_vld = 1'b1; req_his = 4'h1;
    tick(); tick(); tick();
    req_vld = 1'b0;
    checks++; if (free_cnt !== 4'd5) begin errors++; $display("FAIL flush_prep: got free_cnt=%0d expected 5", free_cnt); end
    flush_req = 1'b1;
    tick();
    req_vld = 1'b1;
    #1;
    checks++; if (req_rdy !== 1'b0) begin errors++; $display("FAIL flush_rdy_low: got %0d expected 0", req_rdy); end
    cpl_vld = 1'b1; cpl_last = 1'b1; cpl_tag = 3'd1;
    tick();
    checks++; if (free_cnt !== 4'd6 || init_vld !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL flush_free1: got free_cnt=%0d vld=%0d done=%0d expected 6/0/0", free_cnt, init_vld, flush_done); end
    cpl_vld = 1'b0;
    tick(); tick();
    cpl_vld = 1'b1; cpl_tag = 3'd0;
    tick();
    checks++; if (free_cnt !== 4'd7 || flush_done !== 1'b0) begin errors++; $display("FAIL flush_free0: got free_cnt=%0d done=%0d expected 7/0", free_cnt, flush_done); end
    cpl_vld = 1'b0;
    tick();
    cpl_vld = 1'b1; cpl_tag = 3'd2;
    flush_req = 1'b0;
    tick();
    checks++; if (free_cnt !== 4'd8 || flush_done !== 1'b0 || req_rdy !== 1'b0) begin errors++; $display("FAIL flush_free2: got free_cnt=%0d done=%0d rdy=%0d expected 8/0/0", free_cnt, flush_done, req_rdy); end
    cpl_vld = 1'b0;
    tick();
    checks++; if (flush_done !== 1'b1 || req_rdy !== 1'b0) begin errors++; $display("FAIL flush_done_pulse: got done=%0d rdy=%0d expected 1/0", flush_done, req_rdy); end
    req_vld = 1'b0;
    tick();
    checks++; if (flush_done !== 1'b0 || req_rdy !== 1'b1) begin errors++; $display("FAIL flush_return: got done=%0d rdy=%0d expected 0/1", flush_done, req_rdy); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    req_vld = 1'b1; req_his = 4'h2;
    tick(); tick(); tick(); tick();
    req_vld = 1'b0;
    flush_req = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (req_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy: got %0d expected 0", req_rdy); end
    flush_req = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (free_cnt !== 4'd8 || req_rdy !== 1'b1) begin errors++; $display("FAIL mid_release: got free_cnt=%0d rdy=%0d expected 8/1", free_cnt, req_rdy); end
    req_vld = 1'b1; req_his = 4'h9;
    tick();
    checks++; if (init_vld !== 1'b1 || init_tag !== 3'd0 || init_his !== 4'h9) begin errors++; $display("FAIL mid_first_tag: got vld=%0d tag=%0d his=%0d expected 1/0/9", init_vld, init_tag, init_his); end
    req_vld = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL mid_no_done_%0d: got %0d expected 0", k, flush_done); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_vld = 1'b0; req_his = '0;
    cpl_vld = 1'b0; cpl_tag = '0; cpl_last = 1'b0; flush_req = 1'b0;
    test_reset();
    test_fill();
    test_ooo_free();
    test_simul();
    test_bad_free();
    test_flush_idle();
    test_flush();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
